reg_file: RTL
=============

Name: reg_file

Overview:
- Write-back destination of the pipeline: receives the write-back data word selected in the WB stage and stores it into the architectural register set.
- Register set: R0–R7, SP, IH, T, RA.
- Provides two combinational read ports to the ID stage.
- Provides dedicated always-visible outputs of SP/IH/T/RA for branch, stack and interrupt logic.

Parameters:
- DATA_W, 16, width of every register and data port (matches the data bus).
- ADDR_W, 4, register address width.
- NUM_GPR, 8, number of general registers, R0..R(NUM_GPR-1).
- SP_RESET, 16'hBF00, reset value of SP. All other registers reset to 0.

Ports:
- clk  in  1  pipeline clock; all writes occur on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wb_en  in  1  write strobe from WB stage. Low when write-back op is NOP.
- wb_addr  in  ADDR_W  destination register.
- wb_data  in  DATA_W  write-back data word.
- rd_addr_a  in  ADDR_W  read port A address.
- rd_data_a  out  DATA_W  read port A data.
- rd_addr_b  in  ADDR_W  read port B address.
- rd_data_b  out  DATA_W  read port B data.
- sp_out  out  DATA_W  current SP.
- ih_out  out  DATA_W  current IH; bit 15 is the interrupt-enable flag.
- t_out  out  DATA_W  current T.
- ra_out  out  DATA_W  current RA.

Behaviour:
- Address map:
  - 0–7 → R0–R7
  - 8 → SP
  - 9 → IH
  - 10 → T
  - 11 → RA
  - 12–15 reserved
- Reset:
  - rst high asynchronously forces R0–R7, IH, T, RA to 0 and SP to SP_RESET.
  - All outputs reflect the reset values in the same cycle; no clock is needed.
  - While rst is high, rising edges perform no write.
  - Reset asserted coincident with a write edge: reset wins, the write is lost.
- Write:
  - On the rising edge with wb_en=1 and wb_addr in 0–11, the addressed register takes wb_data.
  - Latency: 1 cycle; the new value is visible on sp_out/ih_out/t_out/ra_out and on read ports from the cycle after the edge.
- Ignored writes:
  - Reserved addresses: the write is silently dropped and no register changes.
  - wb_en=0: no register changes, whatever the value of wb_data (the upstream mux may hold stale or undefined data during NOP).
- Read ports:
  - Purely combinational from the current register contents.
  - A reserved address returns 16'h0000.
  - Ports A and B are independent and may address the same register.
- Simultaneous read and write of the same register in the same cycle: result is defined by REG_FILE_BYPASS_EN (see Optional Feature).
- Dedicated outputs (sp_out etc.) never bypass; they always show the stored value.
- No X propagation: every register has a defined value after reset, and reads never return X.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined:
  - If wb_en=1, wb_addr is a non-reserved address, and wb_addr == rd_addr_a (or rd_addr_b), the port returns wb_data in the same cycle (write-through).
  - This removes the WB→ID hazard for the hazard unit.
- Undefined:
  - Read ports return the pre-write stored value.
  - The hazard unit must stall or forward one extra cycle.

Decomposition:
- Shared define file gains:
  - REG_ADDR_BUS
  - REG_SP, REG_IH, REG_T, REG_RA address constants (8–11)
  - IH_IE_BIT (15)
  - SP_RESET_VAL
- The existing DATA_BUS define is reused for all data widths.
- One sub-module: reg_file_read_port.
  - Contains the address decode and the optional bypass compare.
  - Instantiated twice, for ports A and B.

Test Plan:
- Reset check: pulse rst mid-cycle → all read ports and dedicated outputs show 0, except sp_out=16'hBF00; the reset takes effect before the next clk edge.
- Basic write/read: wb_en=1, wb_addr=3, wb_data=16'h1234, one edge → rd_addr_a=3 gives 16'h1234; R0–R2 and R4–R7 unchanged.
- Special registers: write 9←16'h8001 and 11←16'h00A0 on consecutive edges → ih_out=16'h8001 (IE bit set), ra_out=16'h00A0; reading addresses 9 and 11 matches.
- NOP/reserved writes:
  - wb_en=0 with wb_data=16'hFFFF at wb_addr=2 → R2 unchanged.
  - wb_en=1 at wb_addr=13 → no register changes, and reading address 13 returns 0.
- Same-cycle read/write: R5=16'h0011, then write R5←16'h0022 with rd_addr_a=rd_addr_b=5 → port data shows 16'h0022 with REG_FILE_BYPASS_EN, 16'h0011 without; 16'h0022 in both builds after the edge.
- Reset during write: rst asserted in the same cycle as write R1←16'hBEEF → R1 stays 0 after rst deasserts.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants for the architectural register file: address map, special-register
// addresses, interrupt-enable bit position and reset values.
package reg_file_pkg;

   localparam int DATA_BUS     = 16;
   localparam int REG_ADDR_BUS = 4;
   localparam int NUM_GPR_DEF  = 8;
   localparam int NUM_SPECIAL  = 4;
   localparam int IH_IE_BIT    = 15;

   localparam logic [DATA_BUS-1:0] SP_RESET_VAL = 16'hBF00;

   typedef enum logic [REG_ADDR_BUS-1:0] {
      REG_SP = 4'd8,
      REG_IH = 4'd9,
      REG_T  = 4'd10,
      REG_RA = 4'd11
   } special_reg_e;

   // Addresses 12..15 are reserved and never map to storage.
   function automatic logic addr_is_mapped(input logic [REG_ADDR_BUS-1:0] addr);
      return addr <= REG_RA;
   endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: address decode with zero for reserved addresses.
// With REG_FILE_BYPASS_EN defined, a same-cycle write to the read address is passed through.
module reg_file_read_port
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DATA_BUS,
   parameter int ADDR_W   = REG_ADDR_BUS,
   parameter int NUM_REGS = NUM_GPR_DEF + NUM_SPECIAL
) (
   input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
   input  logic [ADDR_W-1:0]               rd_addr,
   input  logic                            wb_en,
   input  logic [ADDR_W-1:0]               wb_addr,
   input  logic [DATA_W-1:0]               wb_data,
   output logic [DATA_W-1:0]               rd_data
);

   logic rd_mapped;

   assign rd_mapped = (rd_addr < ADDR_W'(NUM_REGS));

`ifdef REG_FILE_BYPASS_EN
   logic bypass_hit;

   // A reserved write address never bypasses, so a read of it still returns zero.
   assign bypass_hit = wb_en && (wb_addr == rd_addr) && rd_mapped;

   always_comb begin
      rd_data = '0;
      if (bypass_hit) begin
         rd_data = wb_data;
      end else if (rd_mapped) begin
         rd_data = regs[rd_addr];
      end
   end
`else
   logic unused_wb;

   assign unused_wb = ^{wb_en, wb_addr, wb_data};

   always_comb begin
      rd_data = '0;
      if (rd_mapped) begin
         rd_data = regs[rd_addr];
      end
   end
`endif

endmodule

// File: rtl/reg_file.sv
// Architectural register file R0-R7, SP, IH, T, RA with two read ports and dedicated
// special-register outputs. Optional write-through on read ports: REG_FILE_BYPASS_EN.
module reg_file
   import reg_file_pkg::*;
#(
   parameter int                DATA_W   = DATA_BUS,
   parameter int                ADDR_W   = REG_ADDR_BUS,
   parameter int                NUM_GPR  = NUM_GPR_DEF,
   parameter logic [DATA_W-1:0] SP_RESET = SP_RESET_VAL
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [DATA_W-1:0] rd_data_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_b,
   output logic [DATA_W-1:0] sp_out,
   output logic [DATA_W-1:0] ih_out,
   output logic [DATA_W-1:0] t_out,
   output logic [DATA_W-1:0] ra_out
);

   localparam int NUM_REGS = NUM_GPR + NUM_SPECIAL;

   logic [NUM_REGS-1:0][DATA_W-1:0] regs;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         localparam logic [DATA_W-1:0] RST_VAL = (gi == int'(REG_SP)) ? SP_RESET : '0;

         logic              wr_hit;
         logic [DATA_W-1:0] reg_d;
         logic [DATA_W-1:0] reg_q;

         // Reserved addresses match no index here, so such writes fall away naturally.
         always_comb begin
            wr_hit = wb_en && (wb_addr == ADDR_W'(gi));
            reg_d  = wr_hit ? wb_data : reg_q;
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               reg_q <= RST_VAL;
            end else begin
               reg_q <= reg_d;
            end
         end

         assign regs[gi] = reg_q;
      end
   endgenerate

   // Dedicated outputs always show stored state, never the in-flight write.
   assign sp_out = regs[REG_SP];
   assign ih_out = regs[REG_IH];
   assign t_out  = regs[REG_T];
   assign ra_out = regs[REG_RA];

   reg_file_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_port_a (
      .regs    (regs),
      .rd_addr (rd_addr_a),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .rd_data (rd_data_a)
   );

   reg_file_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_port_b (
      .regs    (regs),
      .rd_addr (rd_addr_b),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .rd_data (rd_data_b)
   );

endmodule
